// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128 key schedule.
// Latches one cipher key and presents round keys 0..NUM_ROUNDS on a
// valid/ready interface, deriving each next key from the current one in a
// single cycle. Keys use [0:127] ordering: byte 0 occupies bits 0..7.
module aes_key_expand_iter #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [0:127] key_in,
   input  logic         start,
   input  logic         abort,
   input  logic         key_ready,
   output logic [0:127] key_round,
   output logic         key_valid,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // GF(2^8) multiply modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? (p ^ x) : p;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2;
      logic [7:0] a3;
      logic [7:0] a12;
      logic [7:0] a15;
      logic [7:0] a240;
      a2   = gf_mul(a, a);
      a3   = gf_mul(a2, a);
      a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
      a15  = gf_mul(a12, a3);
      a240 = gf_mul(a15, a15);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      a240 = gf_mul(a240, a240);
      return gf_mul(gf_mul(a240, a12), a2);
   endfunction

   // AES S-box: field inverse followed by the affine transform.
   function automatic logic [7:0] sbox_byte(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
             {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   // Round constant for the key that is about to be produced.
   function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   state_t       state_r;
   state_t       state_nx_s;
   logic [0:127] key_r;
   logic [0:127] key_nx_s;
   logic [3:0]   idx_r;
   logic [3:0]   idx_nx_s;
   logic         valid_r;
   logic         valid_nx_s;
   logic         busy_r;
   logic         busy_nx_s;
   logic         done_r;
   logic         done_nx_s;

   logic [7:0]   rcon_s;
   logic [0:31]  w0_s;
   logic [0:31]  w1_s;
   logic [0:31]  w2_s;
   logic [0:31]  w3_s;
   logic [0:31]  rot_s;
   logic [0:31]  t_s;
   logic [0:31]  n0_s;
   logic [0:31]  n1_s;
   logic [0:31]  n2_s;
   logic [0:31]  n3_s;
   logic [0:127] next_key_s;

   // Derive the following round key from the registered one (no extra latency).
   always_comb begin
      rcon_s     = rcon_byte(idx_r + 4'd1);
      w0_s       = key_r[0:31];
      w1_s       = key_r[32:63];
      w2_s       = key_r[64:95];
      w3_s       = key_r[96:127];
      rot_s      = {w3_s[8:31], w3_s[0:7]};
      t_s        = {sbox_byte(rot_s[0:7]) ^ rcon_s, sbox_byte(rot_s[8:15]),
                    sbox_byte(rot_s[16:23]), sbox_byte(rot_s[24:31])};
      n0_s       = w0_s ^ t_s;
      n1_s       = w1_s ^ n0_s;
      n2_s       = w2_s ^ n1_s;
      n3_s       = w3_s ^ n2_s;
      next_key_s = {n0_s, n1_s, n2_s, n3_s};
   end

   // Next-state and next-output decode; abort overrides everything else.
   always_comb begin
      state_nx_s = state_r;
      key_nx_s   = key_r;
      idx_nx_s   = idx_r;
      valid_nx_s = valid_r;
      busy_nx_s  = busy_r;
      done_nx_s  = 1'b0;
      if (abort) begin
         state_nx_s = ST_IDLE;
         valid_nx_s = 1'b0;
         busy_nx_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_nx_s = ST_EMIT;
                  key_nx_s   = key_in;
                  idx_nx_s   = 4'd0;
                  valid_nx_s = 1'b1;
                  busy_nx_s  = 1'b1;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_EMIT: begin
               if (valid_r && key_ready) begin
                  if (idx_r < LAST_IDX) begin
                     key_nx_s = next_key_s;
                     idx_nx_s = idx_r + 4'd1;
                  end else begin
                     state_nx_s = ST_IDLE;
                     valid_nx_s = 1'b0;
                     busy_nx_s  = 1'b0;
                     done_nx_s  = 1'b1;
                  end
               end else begin
                  state_nx_s = ST_EMIT;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
               valid_nx_s = 1'b0;
               busy_nx_s  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         key_r   <= 128'h0;
         idx_r   <= 4'd0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         key_r   <= key_nx_s;
         idx_r   <= idx_nx_s;
         valid_r <= valid_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   assign key_round = key_r;
   assign round_idx = idx_r;
   assign key_valid = valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Directed bench for aes_key_expand_iter using the FIPS-197 key schedule
// example, plus a NUM_ROUNDS=2 instance for the short-schedule build.
module tb_aes_key_expand_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [0:127] key_in;
   logic         start;
   logic         abort;
   logic         key_ready;
   logic [0:127] key_round;
   logic         key_valid;
   logic [3:0]   round_idx;
   logic         busy;
   logic         done;

   logic         start2;
   logic         abort2;
   logic         key_ready2;
   logic [0:127] key_round2;
   logic         key_valid2;
   logic [3:0]   round_idx2;
   logic         busy2;
   logic         done2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } rk_vec_t;

   rk_vec_t vecs [0:10];

   localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_key_expand_iter #(.NUM_ROUNDS(10)) dut (
      .clk(clk), .reset(reset), .key_in(key_in), .start(start), .abort(abort),
      .key_ready(key_ready), .key_round(key_round), .key_valid(key_valid),
      .round_idx(round_idx), .busy(busy), .done(done)
   );

   aes_key_expand_iter #(.NUM_ROUNDS(2)) dut2 (
      .clk(clk), .reset(reset), .key_in(key_in), .start(start2), .abort(abort2),
      .key_ready(key_ready2), .key_round(key_round2), .key_valid(key_valid2),
      .round_idx(round_idx2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_valid"}, key_valid, 128'd0);
      chk({name, "_busy"}, busy, 128'd0);
      chk({name, "_done"}, done, 128'd0);
   endtask

   task automatic chk_key(input string name, input int i);
      chk({name, "_valid"}, key_valid, 128'd1);
      chk({name, "_busy"}, busy, 128'd1);
      chk({name, "_idx"}, round_idx, 128'(vecs[i].idx));
      chk({name, "_key"}, key_round, vecs[i].key);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  exp_idx;
      bit  fin;

      vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
      vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
      vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
      vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      reset      = 1'b0;
      key_in     = CIPHER_KEY;
      start      = 1'b0;
      abort      = 1'b0;
      key_ready  = 1'b0;
      start2     = 1'b0;
      abort2     = 1'b0;
      key_ready2 = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_key", key_round, 128'd0);
      chk("rst_idx", round_idx, 128'd0);
      chk_idle("rst");
      reset = 1'b1;

      // Scenario 1: full schedule with ready held high
      start     = 1'b1;
      key_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         chk_key($sformatf("s1_r%0d", i), i);
         tick();
      end
      chk_idle_done: begin
         chk("s1_done_pulse", done, 128'd1);
         chk("s1_end_valid", key_valid, 128'd0);
         chk("s1_end_busy", busy, 128'd0);
         chk("s1_hold_idx", round_idx, 128'd10);
         chk("s1_hold_key", key_round, vecs[10].key);
      end
      tick();
      chk("s1_done_once", done, 128'd0);

      // Scenario 2: ready pattern 1,0,0,1,0,0,... with stable hold
      start     = 1'b1;
      key_ready = 1'b0;
      tick();
      start   = 1'b0;
      exp_idx = 0;
      fin     = 1'b0;
      for (int c = 0; c < 60 && !fin; c++) begin
         key_ready = (c % 3 == 0);
         chk($sformatf("s2_c%0d_valid", c), key_valid, 128'd1);
         chk($sformatf("s2_c%0d_idx", c), round_idx, 128'(exp_idx));
         chk($sformatf("s2_c%0d_key", c), key_round, vecs[exp_idx].key);
         tick();
         if (key_ready) begin
            if (exp_idx == 10) fin = 1'b1;
            else exp_idx++;
         end
      end
      chk("s2_finished", 128'(fin), 128'd1);
      chk("s2_done", done, 128'd1);

      // Start in the same cycle as done is accepted
      start     = 1'b1;
      key_ready = 1'b0;
      tick();
      start = 1'b0;
      chk_key("s2_restart", 0);

      // Abort alone, then start together with abort (abort wins)
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_idle("abort_idle");
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk_idle("start_abort");
      tick();
      chk_idle("start_abort_after");

      // Scenario 3: start while busy is ignored
      start = 1'b1;
      tick();
      start     = 1'b0;
      key_ready = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         chk_key($sformatf("s3_r%0d", i), i);
         if (i == 4) begin
            start  = 1'b1;
            key_in = 128'h000102030405060708090a0b0c0d0e0f;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start  = 1'b0;
      key_in = CIPHER_KEY;
      chk("s3_done", done, 128'd1);
      tick();

      // Scenario 4: abort at round 6, then clean restart
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         chk_key($sformatf("s4_r%0d", i), i);
         if (i == 6) abort = 1'b1;
         tick();
      end
      abort = 1'b0;
      chk_idle("s4_abort");
      tick();
      chk_idle("s4_abort_after");
      start = 1'b1;
      tick();
      start = 1'b0;
      chk_key("s4_restart", 0);

      // Scenario 5: asynchronous reset between edges at round 3
      tick();
      tick();
      tick();
      chk_key("s5_r3", 3);
      #3;
      reset = 1'b0;
      #1;
      chk("s5_async_key", key_round, 128'd0);
      chk("s5_async_idx", round_idx, 128'd0);
      chk_idle("s5_async");
      tick();
      reset     = 1'b1;
      key_ready = 1'b0;
      chk_idle("s5_after_reset");

      // Scenario 6: NUM_ROUNDS=2 instance
      start2     = 1'b1;
      key_ready2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i <= 2; i++) begin
         chk($sformatf("s6_r%0d_valid", i), key_valid2, 128'd1);
         chk($sformatf("s6_r%0d_idx", i), round_idx2, 128'(i));
         chk($sformatf("s6_r%0d_key", i), key_round2, vecs[i].key);
         tick();
      end
      chk("s6_done", done2, 128'd1);
      chk("s6_valid_end", key_valid2, 128'd0);
      chk("s6_busy_end", busy2, 128'd0);
      tick();
      chk("s6_done_once", done2, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_key_expand_iter.md
Name: aes_key_expand_iter

Overview:
- Iterative AES-128 key schedule that feeds round keys to the encryption round datapath, including the final-round stage that consumes a 128-bit key_round.
- Latches one cipher key and emits round keys 0..NUM_ROUNDS, one per valid/ready handshake, computing each next key from the current one in a single cycle.
- Sits directly upstream of the round stages. The round controller drives key_ready and routes key_round to the round whose index matches round_idx.

Parameters:
- NUM_ROUNDS, 10, index of the last round key emitted. Legal range 1..10; 10 gives the full AES-128 schedule.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- key_in  input  128  cipher key, bit ordering [0:127]. Byte 0 = bits 0..7. Sampled only when start is accepted.
- start  input  1  single-cycle request to begin a schedule. Accepted only when busy=0.
- abort  input  1  synchronous cancel. Returns the block to IDLE.
- key_ready  input  1  consumer accepts key_round this cycle.
- key_round  output  128  current round key, [0:127] ordering.
- key_valid  output  1  key_round and round_idx are valid.
- round_idx  output  4  index of the key on key_round, 0..NUM_ROUNDS.
- busy  output  1  schedule in progress; high in state EMIT.
- done  output  1  one-cycle pulse after the last key is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; key_round=0, key_valid=0, round_idx=0, busy=0, done=0.
- States:
  - IDLE -> EMIT on start=1.
  - EMIT -> EMIT on a handshake with round_idx<NUM_ROUNDS.
  - EMIT -> IDLE on a handshake with round_idx=NUM_ROUNDS.
  - any state -> IDLE on abort=1.
- Start acceptance at edge N:
  - key_round<=key_in, round_idx<=0, key_valid<=1, busy<=1.
  - Round-0 key is visible in the cycle after edge N.
- Handshake (key_valid & key_ready at an edge):
  - If round_idx<NUM_ROUNDS: key_round<=next_key(key_round, RCON[round_idx+1]), round_idx<=round_idx+1, key_valid stays 1.
  - Result: one key per cycle when key_ready is held high. Total NUM_ROUNDS+1 cycles from first valid to last acceptance.
  - If round_idx=NUM_ROUNDS: key_valid<=0, busy<=0, done<=1 for exactly one cycle, key_round and round_idx hold their values.
- key_valid=1 with key_ready=0: key_round and round_idx are held stable. No internal advance, no bubble.
- next_key, with words w0..w3 taken as bits 0-31 .. 96-127:
  - t = SubWord(RotWord(w3)) xor {rcon,8'h00,8'h00,8'h00}.
  - RotWord moves the first byte to the end. SubWord applies the AES S-box to each byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - Purely combinational from the register; no extra latency.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- S-box: four byte instances, combinational. Either a lookup table or GF(2^8) inverse plus affine transform; results must be bit-identical.
- start while busy=1 is ignored; the schedule and key_in latch are unaffected.
- start and abort in the same cycle: abort wins; the block is in IDLE next cycle and start is dropped.
- start in the same cycle as done=1: accepted, because the block is already in IDLE.
- Reset mid-schedule: immediate return to reset values. No partial key or done pulse survives.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and key_ready=1 held high:
  - round 0 = 2b7e1516...4f3c;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 2 = f2c295f27a96b9435935807a7359f67f;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - 11 consecutive valid cycles, then done=1 for 1 cycle.
- Same key, key_ready toggling 1,0,0,1,...: key_round and round_idx stable while ready=0, and the key sequence is identical to scenario 1.
- start pulsed again at round_idx=4 with a different key_in: ignored; the remaining keys match the first key's schedule.
- abort asserted at round_idx=6: next cycle key_valid=0, busy=0, done=0. A following start restarts cleanly from round 0.
- reset driven low at round_idx=3 between clock edges: outputs go to 0 immediately, without waiting for a clock edge.
- NUM_ROUNDS=2 build: only rounds 0,1,2 are emitted, and done pulses after round 2 is accepted.
